composite_timing_gen: RTL and testbench

Parametrised composite-video timing generator, successor to the fixed PAL-only sync generator. It produces the composite sync (`sync_n`), active-video flag, pixel coordinates, field flag and frame/line strobes. It supports PAL (625) and NTSC (525), each in interlaced or progressive (288p/240p) form. The mode is selectable at run time and applied only at frame boundaries. It sits between the clock domain's `clk10` and the pixel/pattern source that drives `vout`.

---
 rtl/composite_pkg.sv | 40 ++++
 rtl/composite_timing_gen_if.sv | 16 +
 rtl/composite_vseq.sv | 44 ++++
 rtl/composite_timing_gen.sv | 132 +++++++++++++
 tb/tb_composite_timing_gen.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/composite_pkg.sv
// rtl/composite_pkg.sv - shared types and vertical timing constants for the composite timing generator
package composite_pkg;

  typedef enum logic [1:0] {
    SEG_NORMAL = 2'd0,
    SEG_SHORT  = 2'd1,
    SEG_LONG   = 2'd2
  } seg_e;

  // Field half-line counter width; covers the largest field (625 half-lines).
  localparam int F_W = 10;

  // Half-lines per field for each latched mode.
  localparam logic [F_W-1:0] FH_PAL_IL  = 10'd625;
  localparam logic [F_W-1:0] FH_PAL_P   = 10'd624;
  localparam logic [F_W-1:0] FH_NTSC_IL = 10'd525;
  localparam logic [F_W-1:0] FH_NTSC_P  = 10'd524;

  // PAL: broad 0-4, equalising 5-9, video, trailing 5 equalising half-lines.
  localparam logic [F_W-1:0] PAL_LONG_END = 10'd5;
  localparam logic [F_W-1:0] PAL_EQ1_END  = 10'd10;
  localparam logic [F_W-1:0] PAL_EQ2_LEN  = 10'd5;

  // NTSC: equalising 0-5, broad 6-11, equalising 12-17, then video.
  localparam logic [F_W-1:0] NTSC_EQ1_END  = 10'd6;
  localparam logic [F_W-1:0] NTSC_LONG_END = 10'd12;
  localparam logic [F_W-1:0] NTSC_EQ2_END  = 10'd18;

  function automatic logic [F_W-1:0] fh_sel(input logic ntsc, input logic il);
    logic [F_W-1:0] fh;
    case ({ntsc, il})
      2'b00:   fh = FH_PAL_P;
      2'b01:   fh = FH_PAL_IL;
      2'b10:   fh = FH_NTSC_P;
      default: fh = FH_NTSC_IL;
    endcase
    return fh;
  endfunction

endpackage

// File: rtl/composite_timing_gen_if.sv
// rtl/composite_timing_gen_if.sv - video timing bus from the generator to the pixel source
interface composite_timing_gen_if #(
  parameter int XW = 10,
  parameter int YW = 10
);
  logic          sync_n;
  logic          active;
  logic [XW-1:0] xpos;
  logic [YW-1:0] ypos;
  logic          field;
  logic          frame_start;
  logic          line_start;

  modport master (output sync_n, active, xpos, ypos, field, frame_start, line_start);
  modport slave  (input  sync_n, active, xpos, ypos, field, frame_start, line_start);
endinterface

// File: rtl/composite_vseq.sv
// rtl/composite_vseq.sv - classifies a field half-line into sync segment and vertical-active state
module composite_vseq
  import composite_pkg::*;
#(
  parameter int PAL_V_START  = 46,
  parameter int NTSC_V_START = 40
) (
  input  logic [F_W-1:0] f,
  input  logic           cfg_ntsc,
  input  logic [F_W-1:0] fh,
  output seg_e           seg,
  output logic           v_act,
  output logic           odd
);

  function automatic seg_e classify(input logic [F_W-1:0] h, input logic n,
                                    input logic [F_W-1:0] fh_i);
    seg_e s;
    s = SEG_NORMAL;
    if (!n) begin
      if (h < PAL_LONG_END)             s = SEG_LONG;
      else if (h < PAL_EQ1_END)         s = SEG_SHORT;
      else if (h >= fh_i - PAL_EQ2_LEN) s = SEG_SHORT;
    end else begin
      if (h < NTSC_EQ1_END)             s = SEG_SHORT;
      else if (h < NTSC_LONG_END)       s = SEG_LONG;
      else if (h < NTSC_EQ2_END)        s = SEG_SHORT;
    end
    return s;
  endfunction

  logic [F_W-1:0] base;
  logic [F_W-1:0] vs;

  // A full video line is an even/odd half-line pair; both halves must be picture lines.
  always_comb begin
    base  = {f[F_W-1:1], 1'b0};
    vs    = cfg_ntsc ? F_W'(NTSC_V_START) : F_W'(PAL_V_START);
    seg   = classify(f, cfg_ntsc, fh);
    odd   = f[0];
    v_act = (seg == SEG_NORMAL) && (classify(base, cfg_ntsc, fh) == SEG_NORMAL) && (base >= vs);
  end

endmodule

// File: rtl/composite_timing_gen.sv
// rtl/composite_timing_gen.sv - PAL/NTSC interlaced/progressive composite sync and pixel timing
module composite_timing_gen
  import composite_pkg::*;
#(
  parameter int PAL_HALF_CLKS   = 384,
  parameter int NTSC_HALF_CLKS  = 381,
  parameter int LINE_SYNC_CLKS  = 56,
  parameter int SHORT_SYNC_CLKS = 28,
  parameter int LONG_SYNC_CLKS  = 328,
  parameter int H_ACT_START     = 126,
  parameter int H_ACT_CLKS      = 624,
  parameter int PAL_V_START     = 46,
  parameter int NTSC_V_START    = 40,
  parameter int XW              = 10,
  parameter int YW              = 10
) (
  input  logic                     clk10,
  input  logic                     rst_n,
  input  logic                     ntsc,
  input  logic                     interlace,
  composite_timing_gen_if.master   tbus
);

  localparam int HALF_MAX = (PAL_HALF_CLKS > NTSC_HALF_CLKS) ? PAL_HALF_CLKS : NTSC_HALF_CLKS;
  localparam int POS_W    = $clog2(HALF_MAX + 1);
  localparam int P_W      = $clog2(2 * HALF_MAX + 1);
  localparam logic [P_W:0] H_BEG = (P_W+1)'(H_ACT_START);
  localparam logic [P_W:0] H_END = (P_W+1)'(H_ACT_START + H_ACT_CLKS);

  logic [POS_W-1:0] pos;
  logic [F_W-1:0]   f;
  logic             field;
  logic             cfg_ntsc;
  logic             cfg_il;

  logic [POS_W-1:0] half;
  logic [F_W-1:0]   fh;
  logic             pos_last;
  logic             f_last;
  logic             frame_wrap;
  seg_e             seg;
  logic             v_act;
  logic             odd;
  logic [P_W-1:0]   p;
  logic             h_act;
  logic             pulse;
  logic [F_W-1:0]   vs;
  logic [F_W-1:0]   base;
  logic [F_W-1:0]   y;
  logic [XW-1:0]    xpos_n;
  logic [YW-1:0]    ypos_n;

  composite_vseq #(
    .PAL_V_START  (PAL_V_START),
    .NTSC_V_START (NTSC_V_START)
  ) u_vseq (
    .f        (f),
    .cfg_ntsc (cfg_ntsc),
    .fh       (fh),
    .seg      (seg),
    .v_act    (v_act),
    .odd      (odd)
  );

  // Mode-dependent geometry, wrap detection and next-output values from the current counters.
  always_comb begin
    half       = cfg_ntsc ? POS_W'(NTSC_HALF_CLKS) : POS_W'(PAL_HALF_CLKS);
    fh         = fh_sel(cfg_ntsc, cfg_il);
    pos_last   = (pos == half - 1'b1);
    f_last     = (f == fh - 1'b1);
    frame_wrap = pos_last && f_last && (field || !cfg_il);
    p          = P_W'(pos) + (odd ? P_W'(half) : '0);
    h_act      = ({1'b0, p} >= H_BEG) && ({1'b0, p} < H_END);
    case (seg)
      SEG_LONG:  pulse = (pos < POS_W'(LONG_SYNC_CLKS));
      SEG_SHORT: pulse = (pos < POS_W'(SHORT_SYNC_CLKS));
      default:   pulse = !odd && (pos < POS_W'(LINE_SYNC_CLKS));
    endcase
    vs     = cfg_ntsc ? F_W'(NTSC_V_START) : F_W'(PAL_V_START);
    base   = {f[F_W-1:1], 1'b0};
    y      = (base - vs) >> 1;
    xpos_n = XW'(p - P_W'(H_ACT_START));
    ypos_n = cfg_il ? YW'({y, field}) : YW'(y);
  end

  // Half-line/field counters; the requested mode is taken only at the frame wrap.
  always_ff @(posedge clk10 or negedge rst_n) begin
    if (!rst_n) begin
      pos      <= '0;
      f        <= '0;
      field    <= 1'b0;
      cfg_ntsc <= 1'b0;
      cfg_il   <= 1'b1;
    end else if (pos_last) begin
      pos <= '0;
      if (f_last) begin
        f     <= '0;
        field <= cfg_il ? ~field : 1'b0;
        if (frame_wrap) begin
          cfg_ntsc <= ntsc;
          cfg_il   <= interlace;
        end
      end else begin
        f <= f + 1'b1;
      end
    end else begin
      pos <= pos + 1'b1;
    end
  end

  // Registered timing outputs, one cycle behind the counters.
  always_ff @(posedge clk10 or negedge rst_n) begin
    if (!rst_n) begin
      tbus.sync_n      <= 1'b1;
      tbus.active      <= 1'b0;
      tbus.xpos        <= '0;
      tbus.ypos        <= '0;
      tbus.field       <= 1'b0;
      tbus.frame_start <= 1'b0;
      tbus.line_start  <= 1'b0;
    end else begin
      tbus.sync_n      <= ~pulse;
      tbus.active      <= v_act && h_act;
      tbus.xpos        <= xpos_n;
      tbus.ypos        <= ypos_n;
      tbus.field       <= field;
      tbus.frame_start <= (f == '0) && (pos == '0) && !field;
      tbus.line_start  <= (seg == SEG_NORMAL) && !odd && (pos == '0);
    end
  end

endmodule

// File: tb/tb_composite_timing_gen.sv
// tb/tb_composite_timing_gen.sv - scoreboard bench for composite_timing_gen with shortened half-lines
module tb_composite_timing_gen;

  localparam int PH  = 20;
  localparam int NH  = 18;
  localparam int LS  = 4;
  localparam int SS  = 2;
  localparam int LG  = 15;
  localparam int HAS = 6;
  localparam int HAC = 28;
  localparam int PVS = 46;
  localparam int NVS = 40;

  typedef struct {
    bit sync_n;
    bit active;
    bit field;
    bit fs;
    bit ls;
    int x;
    int y;
  } exp_t;

  logic clk10;
  logic rst_n;
  logic ntsc;
  logic interlace;

  composite_timing_gen_if #(.XW(10), .YW(10)) tb_if ();

  composite_timing_gen #(
    .PAL_HALF_CLKS   (PH),
    .NTSC_HALF_CLKS  (NH),
    .LINE_SYNC_CLKS  (LS),
    .SHORT_SYNC_CLKS (SS),
    .LONG_SYNC_CLKS  (LG),
    .H_ACT_START     (HAS),
    .H_ACT_CLKS      (HAC),
    .PAL_V_START     (PVS),
    .NTSC_V_START    (NVS),
    .XW              (10),
    .YW              (10)
  ) dut (
    .clk10     (clk10),
    .rst_n     (rst_n),
    .ntsc      (ntsc),
    .interlace (interlace),
    .tbus      (tb_if)
  );

  initial clk10 = 1'b0;
  always #5 clk10 = ~clk10;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  task automatic finish_test();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic int fh_of(input bit n, input bit il);
    if (n) return il ? 525 : 524;
    return il ? 625 : 624;
  endfunction

  function automatic int frame_len(input bit n, input bit il);
    return (il ? 2 : 1) * fh_of(n, il) * (n ? NH : PH);
  endfunction

  // 0 = normal, 1 = equalising, 2 = broad
  function automatic int seg_of(input bit n, input int fh, input int f);
    if (!n) begin
      if (f <= 4) return 2;
      if (f <= 9) return 1;
      if (f >= fh - 5) return 1;
      return 0;
    end
    if (f <= 5)  return 1;
    if (f <= 11) return 2;
    if (f <= 17) return 1;
    return 0;
  endfunction

  // Expected outputs for clock t counted from the start of a frame in mode (n, il).
  function automatic exp_t model(input bit n, input bit il, input int t);
    exp_t e;
    int half, fh, h, pos, fld, f, sg, base, vs, p, pulse;
    half = n ? NH : PH;
    fh   = fh_of(n, il);
    h    = t / half;
    pos  = t % half;
    fld  = (il && h >= fh) ? 1 : 0;
    f    = h - fld * fh;
    sg   = seg_of(n, fh, f);
    base = f - (f % 2);
    vs   = n ? NVS : PVS;
    p    = pos + ((f % 2 == 1) ? half : 0);
    if (sg == 2)      pulse = (pos < LG) ? 1 : 0;
    else if (sg == 1) pulse = (pos < SS) ? 1 : 0;
    else              pulse = (f % 2 == 0 && pos < LS) ? 1 : 0;
    e.sync_n = (pulse == 0);
    e.active = (sg == 0) && (seg_of(n, fh, base) == 0) && (base >= vs) &&
               (p >= HAS) && (p < HAS + HAC);
    e.field  = (fld == 1);
    e.fs     = (f == 0) && (pos == 0) && (fld == 0);
    e.ls     = (sg == 0) && (f % 2 == 0) && (pos == 0);
    e.x      = p - HAS;
    e.y      = il ? 2 * ((base - vs) / 2) + fld : (base - vs) / 2;
    return e;
  endfunction

  // Per-frame statistics gathered from the DUT outputs.
  int mon_cyc = 0;
  int fi      = -1;
  int last_fs = 0;
  int low_run = 0;
  bit prev_act = 0;
  int period  [0:7];
  int max_x   [0:7];
  int max_y   [0:7];
  int rises0  [0:7];
  int broad   [0:7];
  int fld_hi  [0:7];

  initial begin
    for (int i = 0; i < 8; i++) begin
      period[i] = 0; max_x[i] = 0; max_y[i] = 0;
      rises0[i] = 0; broad[i] = 0; fld_hi[i] = 0;
    end
  end

  // Monitor: pops one expectation per presented output cycle and compares.
  always @(negedge clk10) begin
    exp_t e;
    bit   ok;
    mon_cyc++;
    if (q.size() > 0) begin
      e  = q.pop_front();
      ok = (tb_if.sync_n == e.sync_n) && (tb_if.active == e.active) &&
           (tb_if.field == e.field) && (tb_if.frame_start == e.fs) &&
           (tb_if.line_start == e.ls) &&
           (!e.active || (int'(tb_if.xpos) == e.x && int'(tb_if.ypos) == e.y));
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL cycle %0d: got s=%b a=%b fld=%b fs=%b ls=%b x=%0d y=%0d want s=%b a=%b fld=%b fs=%b ls=%b x=%0d y=%0d",
                 mon_cyc, tb_if.sync_n, tb_if.active, tb_if.field, tb_if.frame_start,
                 tb_if.line_start, tb_if.xpos, tb_if.ypos, e.sync_n, e.active, e.field,
                 e.fs, e.ls, e.x, e.y);
        if (bad > 40) begin
          $display("FAIL too_many_errors: got %0d bad cycles want 0", bad);
          finish_test();
        end
      end
      if (tb_if.frame_start) begin
        if (fi >= 0 && fi < 8) period[fi] = mon_cyc - last_fs;
        fi++;
        last_fs = mon_cyc;
      end
      if (fi >= 0 && fi < 8) begin
        if (tb_if.active) begin
          if (int'(tb_if.xpos) > max_x[fi]) max_x[fi] = int'(tb_if.xpos);
          if (int'(tb_if.ypos) > max_y[fi]) max_y[fi] = int'(tb_if.ypos);
          if (!prev_act && !tb_if.field) rises0[fi]++;
        end
        if (tb_if.field) fld_hi[fi] = 1;
        if (!tb_if.sync_n) low_run++;
        else begin
          if (low_run == LG) broad[fi]++;
          low_run = 0;
        end
      end
      prev_act = tb_if.active;
    end
  end

  // Stimulus and reference model: pushes the expectation for each clock edge.
  initial begin
    int   t, frames, ra, rb, rc, post;
    bit   mn, mil, rst_done, stop, last_act;
    exp_t e;
    rst_n = 1'b0; ntsc = 1'b0; interlace = 1'b1;
    t = 0; frames = 0; mn = 1'b0; mil = 1'b1;
    rst_done = 1'b0; stop = 1'b0; last_act = 1'b0; post = 0;
    ra = $urandom_range(20000, 100);
    rb = $urandom_range(10000, 100);
    rc = $urandom_range(15000, 2000);
    repeat (3) @(negedge clk10);
    chk("rst_sync_n", int'(tb_if.sync_n), 1);
    chk("rst_active", int'(tb_if.active), 0);
    chk("rst_xpos", int'(tb_if.xpos), 0);
    chk("rst_ypos", int'(tb_if.ypos), 0);
    chk("rst_field", int'(tb_if.field), 0);
    chk("rst_frame_start", int'(tb_if.frame_start), 0);
    chk("rst_line_start", int'(tb_if.line_start), 0);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 90000 && !stop; cyc++) begin
      @(posedge clk10);
      if (rst_n) begin
        e = model(mn, mil, t);
        q.push_back(e);
        last_act = e.active;
        t++;
        if (t == frame_len(mn, mil)) begin
          t = 0; mn = ntsc; mil = interlace; frames++;
        end
      end
      @(negedge clk10);
      if (frames == 0 && t == ra) interlace = 1'b0;
      if (frames == 1 && t == rb) begin
        ntsc = 1'b1; interlace = 1'b1;
      end
      if (frames == 2 && !rst_done && t >= rc && last_act) begin
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        chk("async_rst_sync_n", int'(tb_if.sync_n), 1);
        chk("async_rst_active", int'(tb_if.active), 0);
        @(negedge clk10);
        @(negedge clk10);
        #2 rst_n = 1'b1;
        t = 0; mn = 1'b0; mil = 1'b1; frames = 3; rst_done = 1'b1;
      end
      if (rst_done) begin
        post++;
        if (post == 3000) stop = 1'b1;
      end
    end
    @(negedge clk10);
    chk("reset_was_applied", int'(rst_done), 1);
    chk("frames_seen", (fi >= 3) ? 1 : 0, 1);
    chk("pal_il_period", period[0], 2 * 625 * PH);
    chk("pal_il_broad_pulses", broad[0], 10);
    chk("pal_il_lines_field0", rises0[0], 287);
    chk("pal_il_max_ypos", max_y[0], 573);
    chk("pal_il_max_xpos", max_x[0], HAC - 1);
    chk("pal_p_period", period[1], 624 * PH);
    chk("pal_p_max_ypos", max_y[1], 286);
    chk("pal_p_field_high", fld_hi[1], 0);
    chk("ntsc_max_xpos", max_x[2], HAC - 1);
    finish_test();
  end

endmodule
